// File: rtl/router_pkg.sv
// Shared NoC router types: VC count, credit depth and the flit channel format.
package router_pkg;

    localparam int unsigned NUM_VCS        = 4;
    localparam int unsigned CREDITS_PER_VC = 4;
    localparam int unsigned VC_W           = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

    typedef enum logic [2:0] {
        FlitI  = 3'd0,
        FlitH  = 3'd1,
        FlitB  = 3'd2,
        FlitT  = 3'd3,
        FlitHt = 3'd4
    } ftype_e;

    typedef logic [VC_W-1:0] vcid_t;
    typedef logic [3:0]      coord_t;
    typedef logic [7:0]      pkt_id_t;

    typedef struct packed {
        ftype_e      ftype;
        vcid_t       fvcid;
        pkt_id_t     pkt_id;
        coord_t      srcx;
        coord_t      srcy;
        coord_t      dstx;
        coord_t      dsty;
        logic [31:0] data;
    } channel_t;

endpackage

// File: rtl/pkt_rx.sv
// NoC ejection receiver: per-VC flit buffers, credit return, packet reassembly into
// descriptors with a valid/ready output, and sticky protocol/destination error flags.
module pkt_rx
    import router_pkg::*;
#(
    parameter int unsigned DX        = 0,
    parameter int unsigned DY        = 0,
    parameter int unsigned BUF_DEPTH = CREDITS_PER_VC,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    input  channel_t           flit_from_noc,
    output logic [NUM_VCS-1:0] credits_to_noc,
    output logic               pkt_valid,
    input  logic               pkt_ready,
    output pkt_id_t            pkt_id,
    output coord_t             pkt_srcx,
    output coord_t             pkt_srcy,
    output vcid_t              pkt_vcid,
    output logic [CNT_W-1:0]   pkt_flit_count,
    output logic               err_ovf,
    output logic               err_proto,
    output logic               err_dst
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {StIdle, StAssm} vc_state_e;

    channel_t         mem_q    [NUM_VCS][BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_VCS];
    logic [PTR_W-1:0] rd_ptr_q [NUM_VCS];
    logic [OCC_W-1:0] occ_q    [NUM_VCS];
    vc_state_e        state_q  [NUM_VCS];
    pkt_id_t          id_q     [NUM_VCS];
    coord_t           srcx_q   [NUM_VCS];
    coord_t           srcy_q   [NUM_VCS];
    logic [CNT_W-1:0] cnt_q    [NUM_VCS];
    vcid_t            rr_q;
    logic [NUM_VCS-1:0] credit_q;

    logic             pkt_valid_q, err_ovf_q, err_proto_q, err_dst_q;
    pkt_id_t          out_id_q;
    coord_t           out_srcx_q, out_srcy_q;
    vcid_t            out_vc_q;
    logic [CNT_W-1:0] out_cnt_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Write side: occupancy is checked before any same-cycle pop.
    logic  push_req, push_ok, drop;
    vcid_t wr_vc;
    assign push_req = (flit_from_noc.ftype != FlitI);
    assign wr_vc    = flit_from_noc.fvcid;
    assign drop     = push_req && (occ_q[wr_vc] == OCC_W'(BUF_DEPTH));
    assign push_ok  = push_req && !drop;

    logic               out_stall, pop_en;
    logic [NUM_VCS-1:0] cand, push_hit, pop_hit;
    vcid_t              pop_vc;
    channel_t           pop_flit;
    int unsigned        idx;

    always_comb begin
        out_stall = pkt_valid_q && !pkt_ready;
        pop_en    = 1'b0;
        pop_vc    = '0;
        idx       = 0;
        for (int v = 0; v < NUM_VCS; v++) begin
            // Only T/HT can emit, so only they wait on a held output register.
            cand[v] = (occ_q[v] != '0) && !(out_stall &&
                      (mem_q[v][rd_ptr_q[v]].ftype inside {FlitT, FlitHt}));
        end
        for (int i = 0; i < NUM_VCS; i++) begin
            idx = (int'(rr_q) + i) % NUM_VCS;
            if (!pop_en && cand[idx]) begin
                pop_en = 1'b1;
                pop_vc = vcid_t'(idx);
            end
        end
        pop_flit = mem_q[pop_vc][rd_ptr_q[pop_vc]];
        push_hit = '0;
        pop_hit  = '0;
        if (push_ok) push_hit[wr_vc] = 1'b1;
        if (pop_en)  pop_hit[pop_vc] = 1'b1;
    end

    vc_state_e        st_cur, st_nxt;
    logic [CNT_W-1:0] cnt_inc, cnt_nxt, emit_cnt;
    pkt_id_t          id_nxt, emit_id;
    coord_t           sx_nxt, sy_nxt, emit_sx, emit_sy;
    logic             emit, set_proto, set_dst, is_head;

    always_comb begin
        st_cur    = state_q[pop_vc];
        st_nxt    = st_cur;
        cnt_inc   = (cnt_q[pop_vc] == CNT_MAX) ? CNT_MAX : cnt_q[pop_vc] + 1'b1;
        cnt_nxt   = cnt_q[pop_vc];
        id_nxt    = id_q[pop_vc];
        sx_nxt    = srcx_q[pop_vc];
        sy_nxt    = srcy_q[pop_vc];
        emit      = 1'b0;
        emit_id   = id_q[pop_vc];
        emit_sx   = srcx_q[pop_vc];
        emit_sy   = srcy_q[pop_vc];
        emit_cnt  = cnt_inc;
        set_proto = 1'b0;
        set_dst   = 1'b0;
        is_head   = pop_flit.ftype inside {FlitH, FlitHt};
        if (pop_en) begin
            if (is_head && (pop_flit.dstx != coord_t'(DX) || pop_flit.dsty != coord_t'(DY))) begin
                set_dst = 1'b1;
            end
            // A new head mid-packet abandons the partial packet and restarts from idle.
            if (st_cur == StAssm && is_head) begin
                set_proto = 1'b1;
                st_cur    = StIdle;
            end
            if (st_cur == StIdle) begin
                case (pop_flit.ftype)
                    FlitH: begin
                        id_nxt  = pop_flit.pkt_id;
                        sx_nxt  = pop_flit.srcx;
                        sy_nxt  = pop_flit.srcy;
                        cnt_nxt = CNT_W'(1);
                        st_nxt  = StAssm;
                    end
                    FlitHt: begin
                        emit     = 1'b1;
                        emit_id  = pop_flit.pkt_id;
                        emit_sx  = pop_flit.srcx;
                        emit_sy  = pop_flit.srcy;
                        emit_cnt = CNT_W'(1);
                        st_nxt   = StIdle;
                    end
                    default: set_proto = 1'b1;
                endcase
            end else begin
                case (pop_flit.ftype)
                    FlitB: cnt_nxt = cnt_inc;
                    FlitT: begin
                        emit   = 1'b1;
                        st_nxt = StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_vc][wr_ptr_q[wr_vc]] <= flit_from_noc;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                occ_q[v]    <= '0;
                state_q[v]  <= StIdle;
                id_q[v]     <= '0;
                srcx_q[v]   <= '0;
                srcy_q[v]   <= '0;
                cnt_q[v]    <= '0;
            end
            rr_q        <= '0;
            credit_q    <= '0;
            pkt_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_srcx_q  <= '0;
            out_srcy_q  <= '0;
            out_vc_q    <= '0;
            out_cnt_q   <= '0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
            err_dst_q   <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push_hit[v]) wr_ptr_q[v] <= ptr_inc(wr_ptr_q[v]);
                if (pop_hit[v])  rd_ptr_q[v] <= ptr_inc(rd_ptr_q[v]);
                if (push_hit[v] && !pop_hit[v])      occ_q[v] <= occ_q[v] + 1'b1;
                else if (!push_hit[v] && pop_hit[v]) occ_q[v] <= occ_q[v] - 1'b1;
            end
            credit_q <= pop_hit;
            if (pop_en) begin
                rr_q            <= (pop_vc == vcid_t'(NUM_VCS - 1)) ? '0 : pop_vc + 1'b1;
                state_q[pop_vc] <= st_nxt;
                cnt_q[pop_vc]   <= cnt_nxt;
                id_q[pop_vc]    <= id_nxt;
                srcx_q[pop_vc]  <= sx_nxt;
                srcy_q[pop_vc]  <= sy_nxt;
            end
            if (emit) begin
                pkt_valid_q <= 1'b1;
                out_id_q    <= emit_id;
                out_srcx_q  <= emit_sx;
                out_srcy_q  <= emit_sy;
                out_vc_q    <= pop_vc;
                out_cnt_q   <= emit_cnt;
            end else if (pkt_valid_q && pkt_ready) begin
                pkt_valid_q <= 1'b0;
            end
            err_ovf_q   <= err_ovf_q | drop;
            err_proto_q <= err_proto_q | set_proto;
            err_dst_q   <= err_dst_q | set_dst;
        end
    end

    assign credits_to_noc = credit_q;
    assign pkt_valid      = pkt_valid_q;
    assign pkt_id         = out_id_q;
    assign pkt_srcx       = out_srcx_q;
    assign pkt_srcy       = out_srcy_q;
    assign pkt_vcid       = out_vc_q;
    assign pkt_flit_count = out_cnt_q;
    assign err_ovf        = err_ovf_q;
    assign err_proto      = err_proto_q;
    assign err_dst        = err_dst_q;

endmodule

// File: tb/tb_pkt_rx.sv
// Bench for pkt_rx: descriptor scoreboard, credit counting monitor, table of single-VC
// packets plus hand sequences for stall, overflow, protocol/destination and reset cases.
module tb_pkt_rx;
    import router_pkg::*;

    localparam int unsigned DX        = 2;
    localparam int unsigned DY        = 1;
    localparam int unsigned BUF_DEPTH = CREDITS_PER_VC;
    localparam int unsigned CNT_W     = 16;

    logic               clk = 1'b0;
    logic               arst_n = 1'b1;
    channel_t           flit = '0;
    logic [NUM_VCS-1:0] credits_to_noc;
    logic               pkt_valid;
    logic               pkt_ready = 1'b1;
    pkt_id_t            pkt_id;
    coord_t             pkt_srcx, pkt_srcy;
    vcid_t              pkt_vcid;
    logic [CNT_W-1:0]   pkt_flit_count;
    logic               err_ovf, err_proto, err_dst;

    pkt_rx #(.DX(DX), .DY(DY), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .flit_from_noc  (flit),
        .credits_to_noc (credits_to_noc),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_id         (pkt_id),
        .pkt_srcx       (pkt_srcx),
        .pkt_srcy       (pkt_srcy),
        .pkt_vcid       (pkt_vcid),
        .pkt_flit_count (pkt_flit_count),
        .err_ovf        (err_ovf),
        .err_proto      (err_proto),
        .err_dst        (err_dst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        pkt_id_t          id;
        coord_t           sx;
        coord_t           sy;
        vcid_t            vc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        int   vc;
        int   len;
        int   id;
        int   sx;
        int   sy;
        logic bad_dst;
    } vec_t;

    exp_t exp_q[$];
    int   credit_cnt[NUM_VCS];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int credit_total();
        int s = 0;
        for (int v = 0; v < NUM_VCS; v++) s += credit_cnt[v];
        return s;
    endfunction

    // Credits and descriptor handshakes are observed on the falling edge.
    always @(negedge clk) begin
        if (arst_n) begin
            for (int v = 0; v < NUM_VCS; v++) if (credits_to_noc[v]) credit_cnt[v]++;
            if (pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pkt: got id 0x%0h, expected no packet", pkt_id);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("desc_id_src_vc", {pkt_id, pkt_srcx, pkt_srcy, pkt_vcid},
                          {e.id, e.sx, e.sy, e.vc});
                    check("flit_count", pkt_flit_count, e.cnt);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input ftype_e ft, input int vc, input int id, input int sx,
                        input int sy, input logic bad);
        flit        = '0;
        flit.ftype  = ft;
        flit.fvcid  = vcid_t'(vc);
        flit.pkt_id = pkt_id_t'(id);
        flit.srcx   = coord_t'(sx);
        flit.srcy   = coord_t'(sy);
        flit.dstx   = coord_t'(bad ? DX + 1 : DX);
        flit.dsty   = coord_t'(DY);
        @(posedge clk);
        #1;
        flit = '0;
    endtask

    task automatic expect_pkt(input int vc, input int len, input int id, input int sx,
                              input int sy);
        exp_q.push_back(exp_t'{pkt_id_t'(id), coord_t'(sx), coord_t'(sy), vcid_t'(vc),
                               CNT_W'(len)});
    endtask

    task automatic send_pkt(input int vc, input int len, input int id, input int sx,
                            input int sy, input logic bad);
        expect_pkt(vc, len, id, sx, sy);
        if (len == 1) begin
            send(FlitHt, vc, id, sx, sy, bad);
        end else begin
            send(FlitH, vc, id, sx, sy, bad);
            for (int i = 1; i < len - 1; i++) send(FlitB, vc, id, sx, sy, bad);
            send(FlitT, vc, id, sx, sy, bad);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pkt_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d packets pending, expected 0", exp_q.size());
        end
        idle(3);
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        #1;
        check("reset_outputs", {credits_to_noc, pkt_valid, pkt_id, pkt_srcx, pkt_srcy,
              pkt_vcid, pkt_flit_count, err_ovf, err_proto, err_dst}, '0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        idle(1);
        for (int v = 0; v < NUM_VCS; v++) credit_cnt[v] = 0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   base;
        tbl[0] = '{vc: 0, len: 1, id: 'h10, sx: 1, sy: 1, bad_dst: 1'b0};
        tbl[1] = '{vc: 1, len: 4, id: 'h21, sx: 3, sy: 0, bad_dst: 1'b0};
        tbl[2] = '{vc: 2, len: 2, id: 'h2a, sx: 5, sy: 7, bad_dst: 1'b0};
        tbl[3] = '{vc: 3, len: 3, id: 'h35, sx: 0, sy: 2, bad_dst: 1'b1};

        #3;
        do_reset();

        // Latency: one edge to write, one to pop; credit and valid appear together.
        send_pkt(0, 1, 'h05, 4, 4, 1'b0);
        check("lat_valid_early", pkt_valid, 1'b0);
        idle(1);
        check("lat_valid", pkt_valid, 1'b1);
        check("lat_credit", credits_to_noc, 4'b0001);
        wait_drain(50);

        foreach (tbl[k]) begin
            base = credit_total();
            send_pkt(tbl[k].vc, tbl[k].len, tbl[k].id, tbl[k].sx, tbl[k].sy, tbl[k].bad_dst);
            wait_drain(100);
            check("tbl_credits", credit_total() - base, tbl[k].len);
            check("tbl_err_dst", err_dst, tbl[k].bad_dst);
            check("tbl_err_proto_ovf", {err_proto, err_ovf}, 2'b00);
        end

        // Interleaved packets with the consumer stalled: second tail must wait.
        do_reset();
        pkt_ready = 1'b0;
        expect_pkt(0, 3, 'h50, 1, 2);
        expect_pkt(1, 3, 'h60, 3, 4);
        send(FlitH, 0, 'h50, 1, 2, 1'b0);
        send(FlitH, 1, 'h60, 3, 4, 1'b0);
        send(FlitB, 0, 'h50, 1, 2, 1'b0);
        send(FlitB, 1, 'h60, 3, 4, 1'b0);
        send(FlitT, 0, 'h50, 1, 2, 1'b0);
        send(FlitT, 1, 'h60, 3, 4, 1'b0);
        idle(20);
        check("stall_credits", credit_total(), 5);
        check("stall_valid", pkt_valid, 1'b1);
        pkt_ready = 1'b1;
        wait_drain(50);
        check("ilv_credits", credit_total(), 6);

        // Overflow: VC2 fills behind a blocked HT, the extra flit is dropped.
        do_reset();
        pkt_ready = 1'b0;
        send_pkt(0, 1, 'h70, 6, 6, 1'b0);
        idle(3);
        for (int i = 0; i < BUF_DEPTH; i++) send_pkt(2, 1, 'h40 + i, 2, 3, 1'b0);
        check("ovf_not_yet", err_ovf, 1'b0);
        send(FlitHt, 2, 'h4f, 2, 3, 1'b0);
        check("err_ovf", err_ovf, 1'b1);
        check("ovf_credits_stalled", credit_total(), 1);
        pkt_ready = 1'b1;
        wait_drain(100);
        check("ovf_credits", credit_total(), BUF_DEPTH + 1);

        // Orphan body then a wrong-destination packet: both still credited.
        do_reset();
        send(FlitB, 3, 'h80, 0, 0, 1'b0);
        idle(3);
        check("proto_orphan", {err_proto, err_dst}, 2'b10);
        send_pkt(3, 2, 'h81, 7, 1, 1'b1);
        wait_drain(50);
        check("dst_err", err_dst, 1'b1);
        check("proto_dst_credits", credit_total(), 3);

        // New head while assembling drops the partial packet.
        do_reset();
        send(FlitH, 0, 'h11, 1, 1, 1'b0);
        send_pkt(0, 3, 'h22, 2, 2, 1'b0);
        wait_drain(50);
        check("assm_head_errs", {err_proto, err_dst}, 2'b10);
        check("assm_head_credits", credit_total(), 4);

        // Reset mid-packet; afterwards an HT on the same VC is a clean packet.
        send(FlitH, 1, 'h90, 3, 3, 1'b0);
        send(FlitB, 1, 'h90, 3, 3, 1'b0);
        do_reset();
        send_pkt(1, 1, 'h91, 5, 5, 1'b0);
        wait_drain(50);
        check("post_reset_errs", {err_ovf, err_proto, err_dst}, 3'b000);
        check("post_reset_credits", credit_total(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_rx.md
Name: pkt_rx

Overview:
Ejection-side receiver for a NoC node's local port. It accepts flits from the router's local output channel into per-VC buffers and returns one credit per drained flit. It reassembles flits into packet descriptors and hands completed packets to the node/stats logic over a valid/ready handshake. It is the downstream mirror of the injection transmitter and also checks protocol and destination correctness.

Parameters:
DX, 0, x coordinate of this node; head flits must carry dstx == DX
DY, 0, y coordinate of this node; head flits must carry dsty == DY
BUF_DEPTH, CREDITS_PER_VC, flit slots per VC; equals the credits the router holds for this port
CNT_W, 16, width of the per-packet flit counter; NUM_VCS is taken from router_pkg

Ports:
clk  in  1  clock
arst_n  in  1  reset, asynchronous, active-low
flit_from_noc  in  channel_t  incoming flit; ftype I means no flit
credits_to_noc  out  logic[NUM_VCS]  one-cycle credit pulse per VC
pkt_valid  out  1  completed packet descriptor available
pkt_ready  in  1  consumer accepts descriptor
pkt_id  out  pkt_id width of head  packet id from head flit
pkt_srcx, pkt_srcy  out  head srcx/srcy widths  packet source coordinates
pkt_vcid  out  fvcid width  VC on which the packet arrived
pkt_flit_count  out  CNT_W  flits received for the packet, including head
err_ovf  out  1  sticky: flit arrived at a full VC buffer
err_proto  out  1  sticky: flit-type sequence violation
err_dst  out  1  sticky: head flit destination differs from (DX,DY)

Behaviour:
- Reset (async, arst_n low):
  - all FIFOs empty, all VC states IDLE, round-robin pointer 0
  - credits_to_noc all 0, pkt_valid 0, descriptor fields 0, all err flags 0
  - reset mid-packet discards all partial state; no credits are returned for discarded flits
- Write:
  - any ftype != I is pushed into FIFO[fvcid] at the clock edge
  - if occupancy at that edge (before any same-cycle pop) equals BUF_DEPTH, the flit is dropped and err_ovf is set
- Drain:
  - at most one flit is popped per cycle, from the first non-empty, non-blocked VC searching from the RR pointer
  - after a pop, the pointer moves to the popped VC + 1, mod NUM_VCS
  - a VC is blocked when its head-of-FIFO flit is T or HT and the output register is full and not being consumed this cycle (pkt_valid && !pkt_ready)
- Credits:
  - a pop of VC v registers credits_to_noc[v] = 1 for exactly the next cycle; otherwise 0
  - discarded or erroneous flits that were written to a FIFO still return their credit when popped
- Per-VC reassembly FSM, states IDLE / ASSM, acting on the popped flit:
  - IDLE + H: capture pkt_id, srcx, srcy; count = 1; go to ASSM
  - IDLE + HT: emit descriptor with count = 1; stay IDLE
  - IDLE + B or T: set err_proto, discard the flit, stay IDLE
  - ASSM + B: count + 1
  - ASSM + T: emit descriptor with count + 1; go to IDLE
  - ASSM + H/HT: set err_proto, drop the partial packet, then process the flit as in IDLE
  - count saturates at 2^CNT_W - 1 and never wraps
- Destination check: on any H/HT whose dstx/dsty differs from DX/DY, set err_dst; the packet is still delivered
- Output: single descriptor register
  - emitting loads it and sets pkt_valid the following cycle
  - pkt_valid and the fields hold stable until pkt_valid && pkt_ready
  - an emit in the same cycle as consumption is allowed (back-to-back delivery)
- Latency: an HT arriving at cycle N into an empty, idle system → pop at N+1 → credit pulse and pkt_valid at N+2
- Throughput: 1 flit/cycle sustained; full-rate injection never overflows while credit discipline is obeyed

Test Plan:
- Single HT on VC0 at cycle 10, pkt_ready=1 → credits_to_noc[0] pulse at 12, pkt_valid at 12, flit_count=1, no errors.
- 4-flit packet (H,B,B,T) on VC1, consecutive cycles → four credit pulses on VC1 at 12..15, one descriptor with flit_count=4 and the captured pkt_id/src.
- Two VCs interleaving 3-flit packets with pkt_ready=0 for 20 cycles → second tail stalls, no loss, both descriptors delivered in completion order once ready rises; credits total 6.
- BUF_DEPTH+1 flits on VC2 with no drain possible (blocked tail, ready=0) → last flit dropped, err_ovf=1.
- B with no preceding head, then an H with dst=(DX+1,DY) → err_proto=1, err_dst=1, credits still returned for both flits, packet delivered.
- Reset asserted mid-packet (after H,B) → all outputs 0 immediately; a new HT after release is delivered with flit_count=1.
